// File: rtl/rv_core_pkg.sv
// Shared constants, opcodes and fetch-state encoding for the minimal RV32I core.
package rv_core_pkg;
  localparam logic [6:0]  OPCODE_OP        = 7'b0110011;
  localparam logic [6:0]  OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    EXECUTE    = 2'd2,
    FAULT      = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC candidate selection (redirect target or pc+4) and alignment check.
module fetch_pc_next (
  input  logic        i_next_pc_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_candidate,
  output logic        o_misaligned
);
  logic [31:0] w_seq_pc;

  // pc+4 wraps naturally at 32 bits
  assign w_seq_pc     = i_pc + 32'd4;
  assign o_candidate  = i_next_pc_valid ? i_next_pc : w_seq_pc;
  assign o_misaligned = (o_candidate[1:0] != 2'b00);
endmodule

// File: rtl/fetch_unit_rv.sv
// Single-issue instruction fetch and PC sequencing for the RV32I core.
// Optional FETCH_WAIT timeout fault enabled by defining FETCH_UNIT_RV_TIMEOUT_EN.
//
// state      | meaning
// FETCH_REQ  | request word at pc, hold until imem accepts
// FETCH_WAIT | request accepted, waiting for response word
// EXECUTE    | instruction held for the ALU until exec_done
// FAULT      | misaligned target (or fetch timeout); held until reset
module fetch_unit_rv
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic        register_type_alu,
  output logic        immediate_type_alu,
  output logic [31:0] pc,
  input  logic        exec_done,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] retired_count,
  output logic        fetch_fault
);
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit_rv: RESET_PC must be 4-byte aligned");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("fetch_unit_rv: TIMEOUT_CYCLES must fit the 16-bit wait counter");
  end

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, r_instr, r_retired;
  logic [31:0]  w_candidate;
  logic         w_misaligned;
  logic         w_take_rsp, w_retire;

  fetch_pc_next u_pc_next (
    .i_next_pc_valid (next_pc_valid),
    .i_pc            (r_pc),
    .i_next_pc       (next_pc),
    .o_candidate     (w_candidate),
    .o_misaligned    (w_misaligned)
  );

`ifdef FETCH_UNIT_RV_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait_cnt;
  logic        w_timeout;

  // a response arriving on the limit cycle takes priority over the fault
  assign w_timeout = (r_state == FETCH_WAIT) && !imem_rsp_valid && (r_wait_cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset || r_state != FETCH_WAIT) begin
      r_wait_cnt <= '0;
    end else if (!imem_rsp_valid) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_take_rsp   = 1'b0;
    w_retire     = 1'b0;
    unique case (r_state)
      FETCH_REQ:  if (imem_req_ready) w_state_next = FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          w_take_rsp   = 1'b1;
          w_state_next = EXECUTE;
        end else if (w_timeout) begin
          w_state_next = FAULT;
        end
      end
      EXECUTE: begin
        if (exec_done) begin
          w_retire     = 1'b1;
          w_state_next = w_misaligned ? FAULT : FETCH_REQ;
        end
      end
      FAULT:   w_state_next = FAULT;
      default: w_state_next = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= FETCH_REQ;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take_rsp) r_instr <= imem_rsp_data;
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
        if (!w_misaligned) r_pc <= w_candidate;
      end
    end
  end

  assign imem_req_valid     = (r_state == FETCH_REQ);
  assign imem_req_addr      = r_pc;
  assign pc                 = r_pc;
  assign instruction        = r_instr;
  assign instruction_valid  = (r_state == EXECUTE);
  assign register_type_alu  = instruction_valid && (r_instr[6:0] == OPCODE_OP);
  assign immediate_type_alu = instruction_valid && (r_instr[6:0] == OPCODE_OP_IMM);
  assign retired_count      = r_retired;
  assign fetch_fault        = (r_state == FAULT);
endmodule
